// File: rtl/halut_decoder_ctrl.sv
// Sequencer in front of one halut_decoder: LUT load forwarding, row stepping and a
// 2-entry result FIFO. Optional counters enabled by `define HALUT_DEC_CTRL_PERF_EN.
module halut_decoder_ctrl #(
   parameter int unsigned K              = 16,
   parameter int unsigned C              = 32,
   parameter int unsigned DataTypeWidth  = 16,
   parameter int unsigned TreeDepth      = $clog2(K),
   parameter int unsigned CAddrWidth     = $clog2(C),
   parameter int unsigned TotalAddrWidth = $clog2(C*K)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      lut_we_i,
   input  logic [TotalAddrWidth-1:0] lut_waddr_i,
   input  logic [DataTypeWidth-1:0]  lut_wdata_i,
   output logic                      lut_wready_o,
   input  logic                      row_valid_i,
   input  logic [C*TreeDepth-1:0]    row_k_i,
   output logic                      row_ready_o,
   output logic [TotalAddrWidth-1:0] dec_waddr_o,
   output logic [DataTypeWidth-1:0]  dec_wdata_o,
   output logic                      dec_we_o,
   output logic [CAddrWidth-1:0]     dec_c_addr_o,
   output logic [TreeDepth-1:0]      dec_k_addr_o,
   output logic                      dec_decoder_o,
   input  logic [31:0]               dec_result_i,
   input  logic                      dec_valid_i,
   output logic                      res_valid_o,
   output logic [31:0]               res_data_o,
   input  logic                      res_ready_i,
   output logic [31:0]               rows_done_o,
   output logic [31:0]               stall_cycles_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e                      state_r, state_s;
   logic [CAddrWidth-1:0]       cnt_r, cnt_s;
   logic [C-1:0][TreeDepth-1:0] row_k_r, row_k_s;
   logic [1:0]                  tag_r;
   logic                        tag_push_s;
   logic [1:0]                  inflight_r;
   logic [1:0]                  fifo_cnt_r;
   logic [31:0]                 fifo_head_r;
   logic [31:0]                 fifo_tail_r;
   logic                        last_s;
   logic                        credit_ok_s;
   logic                        row_acc_s;
   logic                        cap_s;
   logic                        pop_s;
   // Capture timing is fixed by the tag pipeline; the decoder's valid is implied there.
   logic                        dec_valid_unused_s;

   assign dec_valid_unused_s = dec_valid_i;

   assign last_s       = (cnt_r == CAddrWidth'(C-1));
   assign credit_ok_s  = (({1'b0, fifo_cnt_r} + {1'b0, inflight_r}) < 3'd2);
   assign lut_wready_o = (state_r == ST_IDLE) && (inflight_r == 2'd0);
   assign row_ready_o  = !rst_i && ((state_r != ST_RUN) || last_s) && credit_ok_s
                         && !(lut_we_i && (state_r == ST_IDLE));
   assign row_acc_s    = row_valid_i && row_ready_o;
   assign cap_s        = tag_r[1];
   assign pop_s        = res_valid_o && res_ready_i;

   assign dec_we_o     = lut_we_i && lut_wready_o;
   assign dec_waddr_o  = lut_waddr_i;
   assign dec_wdata_o  = lut_wdata_i;
   assign res_valid_o  = (fifo_cnt_r != 2'd0);
   assign res_data_o   = fifo_head_r;

   // Next-state logic; the last RUN cycle doubles as drain when a new row follows.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      row_k_s    = row_k_r;
      tag_push_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DRAIN: begin
            if (row_acc_s) begin
               state_s = ST_RUN;
               cnt_s   = {CAddrWidth{1'b0}};
               row_k_s = row_k_i;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!last_s) begin
               cnt_s = cnt_r + CAddrWidth'(1'b1);
            end else begin
               tag_push_s = 1'b1;
               if (row_acc_s) begin
                  state_s = ST_RUN;
                  cnt_s   = {CAddrWidth{1'b0}};
                  row_k_s = row_k_i;
               end else begin
                  state_s = ST_DRAIN;
               end
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Decoder drive decoded from the state registers.
   always_comb begin
      dec_decoder_o = 1'b0;
      dec_c_addr_o  = {CAddrWidth{1'b0}};
      dec_k_addr_o  = {TreeDepth{1'b0}};
      case (state_r)
         ST_RUN: begin
            dec_decoder_o = 1'b1;
            dec_c_addr_o  = cnt_r;
            dec_k_addr_o  = row_k_r[cnt_r];
         end
         ST_DRAIN: begin
            dec_decoder_o = 1'b1;
         end
         default: begin
            dec_decoder_o = 1'b0;
         end
      endcase
   end

   // Sequencer state, row register and capture tag pipeline.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CAddrWidth{1'b0}};
         row_k_r <= {(C*TreeDepth){1'b0}};
         tag_r   <= 2'b00;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         row_k_r <= row_k_s;
         tag_r   <= {tag_r[0], tag_push_s};
      end
   end

   // Credit count and 2-entry FWFT result FIFO (head is the output register).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight_r  <= 2'd0;
         fifo_cnt_r  <= 2'd0;
         fifo_head_r <= 32'd0;
         fifo_tail_r <= 32'd0;
      end else begin
         case ({row_acc_s, cap_s})
            2'b10:   inflight_r <= inflight_r + 2'd1;
            2'b01:   inflight_r <= inflight_r - 2'd1;
            default: inflight_r <= inflight_r;
         endcase
         case ({cap_s, pop_s})
            2'b10: begin
               if (fifo_cnt_r == 2'd0) begin
                  fifo_head_r <= dec_result_i;
               end else begin
                  fifo_tail_r <= dec_result_i;
               end
               fifo_cnt_r <= fifo_cnt_r + 2'd1;
            end
            2'b01: begin
               fifo_head_r <= fifo_tail_r;
               fifo_cnt_r  <= fifo_cnt_r - 2'd1;
            end
            2'b11: begin
               if (fifo_cnt_r == 2'd2) begin
                  fifo_head_r <= fifo_tail_r;
                  fifo_tail_r <= dec_result_i;
               end else begin
                  fifo_head_r <= dec_result_i;
               end
            end
            default: begin
               fifo_cnt_r <= fifo_cnt_r;
            end
         endcase
      end
   end

`ifdef HALUT_DEC_CTRL_PERF_EN
   logic [31:0] rows_done_r;
   logic [31:0] stall_cycles_r;

   // Saturating performance counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rows_done_r    <= 32'd0;
         stall_cycles_r <= 32'd0;
      end else begin
         if (cap_s && (rows_done_r != 32'hFFFF_FFFF)) begin
            rows_done_r <= rows_done_r + 32'd1;
         end else begin
            rows_done_r <= rows_done_r;
         end
         if (row_valid_i && !row_ready_o && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
      end
   end

   assign rows_done_o    = rows_done_r;
   assign stall_cycles_o = stall_cycles_r;
`else
   assign rows_done_o    = 32'd0;
   assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_halut_decoder_ctrl.sv
// Directed bench for halut_decoder_ctrl with a behavioural INT halut_decoder model
// (one read stage, one accumulate stage, result presented after c=C-1).
module tb_halut_decoder_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         lut_we_i;
   logic [8:0]   lut_waddr_i;
   logic [15:0]  lut_wdata_i;
   logic         lut_wready_o;
   logic         row_valid_i;
   logic [127:0] row_k_i;
   logic         row_ready_o;
   logic [8:0]   dec_waddr_o;
   logic [15:0]  dec_wdata_o;
   logic         dec_we_o;
   logic [4:0]   dec_c_addr_o;
   logic [3:0]   dec_k_addr_o;
   logic         dec_decoder_o;
   logic [31:0]  dec_result_i;
   logic         dec_valid_i;
   logic         res_valid_o;
   logic [31:0]  res_data_o;
   logic         res_ready_i;
   logic [31:0]  rows_done_o;
   logic [31:0]  stall_cycles_o;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int we_cnt = 0;
   int we_last_t = 0;
   int acc_t[$];
   int res_t[$];
   logic [31:0] res_d[$];

   halut_decoder_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lut_we_i(lut_we_i), .lut_waddr_i(lut_waddr_i), .lut_wdata_i(lut_wdata_i),
      .lut_wready_o(lut_wready_o),
      .row_valid_i(row_valid_i), .row_k_i(row_k_i), .row_ready_o(row_ready_o),
      .dec_waddr_o(dec_waddr_o), .dec_wdata_o(dec_wdata_o), .dec_we_o(dec_we_o),
      .dec_c_addr_o(dec_c_addr_o), .dec_k_addr_o(dec_k_addr_o), .dec_decoder_o(dec_decoder_o),
      .dec_result_i(dec_result_i), .dec_valid_i(dec_valid_i),
      .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_ready_i(res_ready_i),
      .rows_done_o(rows_done_o), .stall_cycles_o(stall_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   // Decoder model: LUT[c][k] at address {c,k}, sum over c=0..31 emitted after c=31.
   logic [15:0] lut_m [0:511];
   logic        p1_en = 1'b0;
   logic [4:0]  p1_c = 5'd0;
   logic [15:0] p1_val = 16'd0;
   logic [31:0] acc_m = 32'd0;
   logic [31:0] result_m = 32'd0;
   logic        valid_m = 1'b0;

   assign dec_result_i = result_m;
   assign dec_valid_i  = valid_m;

   always @(posedge clk_i) begin
      if (dec_we_o) lut_m[dec_waddr_o] <= dec_wdata_o;
      p1_en   <= dec_decoder_o;
      p1_c    <= dec_c_addr_o;
      p1_val  <= lut_m[{dec_c_addr_o, dec_k_addr_o}];
      valid_m <= 1'b0;
      if (p1_en) begin
         if (p1_c == 5'd31) begin
            result_m <= acc_m + 32'(p1_val);
            valid_m  <= 1'b1;
            acc_m    <= 32'd0;
         end else if (p1_c == 5'd0) begin
            acc_m <= 32'(p1_val);
         end else begin
            acc_m <= acc_m + 32'(p1_val);
         end
      end
   end

   // Handshake monitor: records edge indices of row accepts, LUT writes and result pops.
   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (dec_we_o) begin
         we_cnt    <= we_cnt + 1;
         we_last_t <= cyc;
      end
      if (row_valid_i && row_ready_o) acc_t.push_back(cyc);
      if (res_valid_o && res_ready_i) begin
         res_t.push_back(cyc);
         res_d.push_back(res_data_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      acc_t.delete();
      res_t.delete();
      res_d.delete();
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_row(input logic [127:0] k, output bit ok);
      ok = 1'b0;
      row_valid_i = 1'b1;
      row_k_i = k;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (row_ready_o) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_i);
      end
      @(negedge clk_i);
      row_valid_i = 1'b0;
   endtask

   task automatic wait_res(input string tag, input int n);
      int i = 0;
      while (res_d.size() < n && i < 400) begin
         @(negedge clk_i);
         i++;
      end
      check(tag, 32'(res_d.size()), 32'(n));
   endtask

   initial begin
      $display("[TB] watchdog armed");
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [127:0] k0, k1, k15, kmod;
      k0  = 128'd0;
      k1  = {32{4'h1}};
      k15 = {32{4'hF}};
      for (int c = 0; c < 32; c++) kmod[c*4 +: 4] = 4'(c % 16);

      rst_i = 1'b1; lut_we_i = 1'b0; lut_waddr_i = 9'd0; lut_wdata_i = 16'd0;
      row_valid_i = 1'b0; row_k_i = 128'd0; res_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_wready", 32'(lut_wready_o), 32'd1);
      check("rst_row_ready", 32'(row_ready_o), 32'd0);
      check("rst_decoder", 32'(dec_decoder_o), 32'd0);
      check("rst_res_valid", 32'(res_valid_o), 32'd0);
      check("rst_res_data", res_data_o, 32'd0);
      check("rst_we", 32'(dec_we_o), 32'd0);
      check("rst_rows_done", rows_done_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("idle_row_ready", 32'(row_ready_o), 32'd1);

      // LUT load LUT[c][k] = c + k
      for (int i = 0; i < 512; i++) begin
         lut_we_i = 1'b1;
         lut_waddr_i = 9'(i);
         lut_wdata_i = 16'((i >> 4) + (i & 15));
         if (i == 0) row_valid_i = 1'b1;
         #1;
         if (i == 0) begin
            check("lut_prio_row_ready", 32'(row_ready_o), 32'd0);
            row_valid_i = 1'b0;
         end
         check("lut_write", 32'({lut_wready_o, dec_we_o, dec_waddr_o, dec_wdata_o}),
               32'({1'b1, 1'b1, 9'(i), 16'((i >> 4) + (i & 15))}));
         @(negedge clk_i);
      end
      lut_we_i = 1'b0;
      check("lut_we_count", 32'(we_cnt), 32'd512);

      // single row, all k=0
      res_ready_i = 1'b1;
      clear_logs();
      send_row(k0, ok);
      check("r1_accept", 32'(ok), 32'd1);
      for (int j = 0; j < 32; j++) begin
         #1;
         check("r1_issue", 32'({dec_decoder_o, dec_c_addr_o, dec_k_addr_o}), 32'({1'b1, 5'(j), 4'd0}));
         check("r1_ready", 32'(row_ready_o), 32'(j == 31));
         @(negedge clk_i);
      end
      #1;
      check("r1_drain", 32'({dec_decoder_o, dec_c_addr_o, dec_k_addr_o}), 32'({1'b1, 5'd0, 4'd0}));
      @(negedge clk_i);
      #1;
      check("r1_idle", 32'(dec_decoder_o), 32'd0);
      wait_res("r1_count", 1);
      check("r1_data", res_d[0], 32'd496);
      check("r1_latency", 32'(res_t[0] - acc_t[0]), 32'd35);

      // three back-to-back rows
      clear_logs();
      send_row(k0, ok);  check("b2b_acc0", 32'(ok), 32'd1);
      send_row(k1, ok);  check("b2b_acc1", 32'(ok), 32'd1);
      send_row(k15, ok); check("b2b_acc2", 32'(ok), 32'd1);
      wait_res("b2b_count", 3);
      check("b2b_data0", res_d[0], 32'd496);
      check("b2b_data1", res_d[1], 32'd528);
      check("b2b_data2", res_d[2], 32'd976);
      check("b2b_acc_gap1", 32'(acc_t[1] - acc_t[0]), 32'd32);
      check("b2b_acc_gap2", 32'(acc_t[2] - acc_t[1]), 32'd32);
      check("b2b_res_gap1", 32'(res_t[1] - res_t[0]), 32'd32);
      check("b2b_res_gap2", 32'(res_t[2] - res_t[1]), 32'd32);
      check("b2b_latency", 32'(res_t[0] - acc_t[0]), 32'd35);

      // back-pressure: four rows offered with res_ready_i low
      repeat (5) @(negedge clk_i);
      clear_logs();
      res_ready_i = 1'b0;
      send_row(k0, ok); check("bp_acc0", 32'(ok), 32'd1);
      send_row(k1, ok); check("bp_acc1", 32'(ok), 32'd1);
      row_valid_i = 1'b1;
      row_k_i = k15;
      repeat (80) @(negedge clk_i);
      #1;
      check("bp_blocked", 32'(row_ready_o), 32'd0);
      check("bp_accepted", 32'(acc_t.size()), 32'd2);
      check("bp_head_valid", 32'(res_valid_o), 32'd1);
      check("bp_head_data", res_data_o, 32'd496);
      @(negedge clk_i);
      res_ready_i = 1'b1;
      send_row(k15, ok);  check("bp_acc2", 32'(ok), 32'd1);
      send_row(kmod, ok); check("bp_acc3", 32'(ok), 32'd1);
      wait_res("bp_count", 4);
      check("bp_data0", res_d[0], 32'd496);
      check("bp_data1", res_d[1], 32'd528);
      check("bp_data2", res_d[2], 32'd976);
      check("bp_data3", res_d[3], 32'd736);

      // reset in the middle of a row
      repeat (5) @(negedge clk_i);
      clear_logs();
      send_row(k1, ok);
      check("mr_accept", 32'(ok), 32'd1);
      repeat (10) @(negedge clk_i);
      #1;
      check("mr_at_c10", 32'(dec_c_addr_o), 32'd10);
      rst_i = 1'b1;
      @(negedge clk_i);
      #1;
      check("mr_decoder", 32'(dec_decoder_o), 32'd0);
      check("mr_c_addr", 32'(dec_c_addr_o), 32'd0);
      check("mr_wready", 32'(lut_wready_o), 32'd1);
      check("mr_res_valid", 32'(res_valid_o), 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      send_row(k0, ok);
      check("mr_accept2", 32'(ok), 32'd1);
      wait_res("mr_count", 1);
      check("mr_data", res_d[0], 32'd496);
      repeat (40) @(negedge clk_i);
      check("mr_no_extra", 32'(res_d.size()), 32'd1);

      // LUT write requested while a row is in flight
      clear_logs();
      send_row(k0, ok);
      check("lw_accept", 32'(ok), 32'd1);
      lut_we_i = 1'b1;
      lut_waddr_i = 9'd80;
      lut_wdata_i = 16'd100;
      #1;
      check("lw_stall", 32'(lut_wready_o), 32'd0);
      check("lw_gated", 32'(dec_we_o), 32'd0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (we_cnt == 513) break;
      end
      lut_we_i = 1'b0;
      check("lw_count", 32'(we_cnt), 32'd513);
      check("lw_time", 32'(we_last_t - acc_t[0]), 32'd35);
      wait_res("lw_res_count", 1);
      check("lw_old_data", res_d[0], 32'd496);
      clear_logs();
      send_row(k0, ok);
      check("lw_accept2", 32'(ok), 32'd1);
      wait_res("lw_res_count2", 1);
      check("lw_new_data", res_d[0], 32'd591);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/halut_decoder_ctrl.md
Name: halut_decoder_ctrl

Overview:
Sequencer in front of one halut_decoder instance.
- Accepts LUT load writes from the host and forwards them to the decoder write port.
- Accepts encoded rows (one k index per codebook) over valid/ready and steps c_addr 0..C-1 while holding decoder_i high.
- Captures each finished 32-bit sum into a 2-entry output FIFO with valid/ready.
- Sustains one row every C cycles, back-to-back.

Parameters:
K, 16, prototypes per codebook
C, 32, codebooks per row
DataTypeWidth, 16, LUT entry width
TreeDepth, $clog2(K), k index width
CAddrWidth, $clog2(C), c index width
TotalAddrWidth, $clog2(C*K), LUT write address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
lut_we_i  in  1  host LUT write request
lut_waddr_i  in  TotalAddrWidth  host LUT address {c,k}
lut_wdata_i  in  DataTypeWidth  host LUT data
lut_wready_o  out  1  LUT write accepted this cycle
row_valid_i  in  1  encoded row valid
row_k_i  in  C*TreeDepth  k for codebook c at [c*TreeDepth +: TreeDepth]
row_ready_o  out  1  row accepted when valid&ready
dec_waddr_o  out  TotalAddrWidth  to decoder waddr_i
dec_wdata_o  out  DataTypeWidth  to decoder wdata_i
dec_we_o  out  1  to decoder we_i
dec_c_addr_o  out  CAddrWidth  to decoder c_addr_i
dec_k_addr_o  out  TreeDepth  to decoder k_addr_i
dec_decoder_o  out  1  to decoder decoder_i
dec_result_i  in  32  from decoder result_o
dec_valid_i  in  1  from decoder valid_o
res_valid_o  out  1  result available
res_data_o  out  32  result (FP32 or INT32 per decoder build)
res_ready_i  in  1  result consumed when valid&ready

Behaviour:
- Reset is synchronous and active-high on rst_i; the only clock is clk_i.
- Reset state: IDLE. All outputs are 0 except lut_wready_o=1. FIFO empty, in-flight count 0, capture tags cleared.
- Reset asserted mid-row: same reset values. dec_decoder_o=0 the next cycle, which clears the decoder's accumulator. The partial row is discarded.
- States:
  - IDLE: dec_decoder_o=0.
  - RUN: issue c_addr=cnt, k_addr=row_k[cnt], dec_decoder_o=1.
  - DRAIN: dec_decoder_o=1, c_addr=0, k_addr=0. Exactly one cycle.
- Credits: inflight counts rows accepted but not yet captured. row_ready_o = (state!=RUN || cnt==C-1) && (fifo_count+inflight<2) && !lut_we_i_in_IDLE.
- Row acceptance: latches row_k_i into the row register, cnt:=0, next state RUN. Accept latency: handshake at T, c=0 issued at T+1.
- RUN, cnt<C-1: cnt increments.
- RUN, cnt==C-1:
  - Pushes a capture tag into a 2-stage shift register.
  - If a row is accepted the same cycle, next state is RUN with cnt=0. This is back-to-back operation; that cycle also serves as the drain cycle.
  - Otherwise next state is DRAIN.
- DRAIN: a row may be accepted in DRAIN (next state RUN); otherwise next state is IDLE.
- Capture: when the tag exits stage 2 (two cycles after c=C-1 was issued):
  - push dec_result_i into the FIFO;
  - decrement inflight;
  - dec_valid_i must be 1 at that point.
  Row accepted at T gives res_valid_o at T+C+3.
- FIFO: 2 entries, registered output, first-word-fall-through at res_data_o.
  - Simultaneous push and pop at full is legal.
  - Credits make overflow impossible.
  - Push and pop in the same cycle keep the count unchanged.
- LUT write:
  - lut_wready_o=1 only in IDLE with inflight==0.
  - dec_we_o = lut_we_i & lut_wready_o; waddr/wdata pass through combinationally.
  - Writes outside that window stall: lut_wready_o=0 and the host holds its request.
  - A LUT write has priority over a row in the same IDLE cycle.
- Counters: cnt wraps C-1 to 0 only via a new row.
- Invariants: inflight never exceeds 2; fifo_count+inflight never exceeds 2.

Optional Feature:
HALUT_DEC_CTRL_PERF_EN.
- Defined: adds outputs rows_done_o[31:0] and stall_cycles_o[31:0], reset to 0.
  - rows_done_o increments on each FIFO push.
  - stall_cycles_o increments each cycle row_valid_i=1 && row_ready_o=0.
  - Both saturate at 2^32-1.
- Undefined: both ports exist and are tied to 0; no counter flops.

Test Plan:
- Reset, then 512 host writes LUT[c][k]=c+k (INT decoder) -> dec_we_o pulses 512 times with matching addresses, lut_wready_o=1 throughout.
- One row with all k=0 accepted at T -> c_addr 0..31 on T+1..T+32, DRAIN at T+33, res_valid_o at T+35 with res_data_o=496.
- Three back-to-back rows (k=0, all k=1, all k=15) with res_ready_i=1 -> no DRAIN between rows, results 496, 528, 976 spaced 32 cycles apart.
- res_ready_i=0, four rows offered -> two rows accepted, then row_ready_o=0. Releasing res_ready_i yields the remaining results in order with no loss.
- rst_i asserted at cnt=10 of a row -> next cycle all outputs at reset values and dec_decoder_o=0. A new all-k=0 row then returns 496.
- LUT write requested while a row is in flight -> lut_wready_o=0 until the result is captured, then the write is accepted and the next row reflects the new value.
